dcache_responder: RTL and testbench

- Data-cache responder: the far end of the pipeline's dcache interface. It serves the memory stage's address, byte write-enables, read-enable and write data, and returns read data.
- Direct-mapped, write-through, no-write-allocate cache.
- Line refills and write-throughs go over a valid/ready memory port to the backing memory.
- Asserts `stall` to freeze the pipeline while a miss or write is outstanding.

---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_data_array.sv | 40 ++++
 rtl/dcache_responder.sv | 192 +++++++++++++++++++
 tb/tb_dcache_responder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-through data cache responder.
package dcache_pkg;

  localparam int DC_NUM_LINES  = 64;
  localparam int DC_LINE_WORDS = 4;
  localparam int DC_ADDR_W     = 32;

  localparam int OFFSET_W = 2;
  localparam int WIDX_W   = $clog2(DC_LINE_WORDS);
  localparam int SIDX_W   = $clog2(DC_NUM_LINES);

  function automatic int tag_width(input int addr_w, input int num_lines, input int line_words);
    return addr_w - OFFSET_W - $clog2(line_words) - $clog2(num_lines);
  endfunction

  localparam int TAG_W = tag_width(DC_ADDR_W, DC_NUM_LINES, DC_LINE_WORDS);

  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_BEAT,
    ST_WR_REQ,
    ST_WR_DONE
  } dc_state_e;

endpackage

// File: rtl/dcache_data_array.sv
// Synchronous-read data RAM with per-byte write enables; the read register holds when re is low.
module dcache_data_array #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    // NOTE: assign a default first so the hold path is explicit and no latch is inferred.
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[addr];
  end

  // NOTE: the storage itself is never reset; valid bits in the tag store decide what is meaningful.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of process order.
    if (!reset) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate dcache responder with a valid/ready refill port.
// Define DCACHE_STATS_EN to add hit/miss/write counters as extra outputs.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = DC_NUM_LINES,
  parameter int LINE_WORDS = DC_LINE_WORDS,
  parameter int ADDR_W     = DC_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [3:0]        dcache_we,
  input  logic              dcache_re,
  input  logic [31:0]       dcache_din,
  output logic [31:0]       dcache_dout,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_data,
  output logic [3:0]        mem_req_mask,
  input  logic              mem_resp_valid,
`ifdef DCACHE_STATS_EN
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_writes,
`endif
  input  logic [31:0]       mem_resp_data
);

  localparam int WIDX_L   = $clog2(LINE_WORDS);
  localparam int SIDX_L   = $clog2(NUM_LINES);
  localparam int TAG_L    = tag_width(ADDR_W, NUM_LINES, LINE_WORDS);
  localparam int LINE_OFF = OFFSET_W + WIDX_L;
  localparam logic [WIDX_L-1:0] LAST_BEAT = WIDX_L'(LINE_WORDS - 1);

  dc_state_e state_q, state_d;

  logic [TAG_L-1:0]     tag_q [NUM_LINES];
  logic [TAG_L-1:0]     tag_d [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [WIDX_L-1:0]    beat_cnt_q, beat_cnt_d;

  logic [WIDX_L-1:0]        widx;
  logic [SIDX_L-1:0]        sidx;
  logic [TAG_L-1:0]         tag;
  logic                     hit, is_store, is_load, unused_addr_bits;
  logic                     ram_re;
  logic [3:0]               ram_we;
  logic [SIDX_L+WIDX_L-1:0] ram_addr;
  logic [31:0]              ram_wdata;

  assign widx             = dcache_addr[OFFSET_W +: WIDX_L];
  assign sidx             = dcache_addr[LINE_OFF +: SIDX_L];
  assign tag              = dcache_addr[ADDR_W-1 -: TAG_L];
  assign unused_addr_bits = ^dcache_addr[OFFSET_W-1:0];
  assign hit              = valid_q[sidx] && (tag_q[sidx] == tag);
  assign is_store         = |dcache_we;
  assign is_load          = dcache_re && !is_store;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (is_store)             state_d = ST_WR_REQ;
        else if (is_load && !hit) state_d = ST_RD_REQ;
      end
      ST_RD_REQ:  if (mem_req_ready) state_d = ST_RD_BEAT;
      ST_RD_BEAT: if (mem_resp_valid && beat_cnt_q == LAST_BEAT) state_d = ST_IDLE;
      ST_WR_REQ:  if (mem_req_ready) state_d = ST_WR_DONE;
      ST_WR_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs: stall, memory request and data-array controls.
  always_comb begin
    stall         = 1'b1;
    mem_req_valid = 1'b0;
    mem_req_rw    = REQ_RD;
    mem_req_addr  = {dcache_addr[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
    mem_req_data  = dcache_din;
    mem_req_mask  = dcache_we;
    ram_re        = 1'b0;
    ram_we        = 4'b0000;
    ram_addr      = {sidx, widx};
    ram_wdata     = dcache_din;
    unique case (state_q)
      ST_IDLE: begin
        stall  = is_store || (is_load && !hit);
        ram_re = is_load && hit;
      end
      ST_RD_REQ: mem_req_valid = 1'b1;
      ST_RD_BEAT: begin
        ram_addr  = {sidx, beat_cnt_q};
        ram_wdata = mem_resp_data;
        if (mem_resp_valid) ram_we = 4'b1111;
      end
      ST_WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = REQ_WR;
        mem_req_addr  = {dcache_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      end
      ST_WR_DONE: begin
        stall = 1'b0;
        // Write-through without allocate: only an already-resident line absorbs the store.
        if (hit) ram_we = dcache_we;
      end
      default: ;
    endcase
  end

  // Tag store, valid bits and refill beat counter.
  always_comb begin
    tag_d      = tag_q;
    valid_d    = valid_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == ST_RD_REQ && mem_req_ready) beat_cnt_d = '0;
    if (state_q == ST_RD_BEAT && mem_resp_valid) begin
      beat_cnt_d = beat_cnt_q + WIDX_L'(1);
      if (beat_cnt_q == LAST_BEAT) begin
        tag_d[sidx]   = tag;
        valid_d[sidx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  dcache_data_array #(
    .AW(SIDX_L + WIDX_L)
  ) u_data_array (
    .clk   (clk),
    .reset (reset),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (dcache_dout)
  );

`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d, writes_q, writes_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    writes_d = writes_q;
    if (state_q == ST_IDLE && is_load && hit)  hits_d   = hits_q + 32'd1;
    if (state_q == ST_IDLE && is_load && !hit) misses_d = misses_q + 32'd1;
    if (state_q == ST_WR_DONE)                 writes_d = writes_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hits_q   <= '0;
      misses_q <= '0;
      writes_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
      writes_q <= writes_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_writes = writes_q;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: stimulus pushes expected read data and memory requests,
// monitors pop and compare when the DUT returns data or issues a memory request.
module tb_dcache_responder;

  localparam int LINE_WORDS = 4;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } req_t;

  logic        clk, reset;
  logic [31:0] dcache_addr, dcache_din, dcache_dout;
  logic [3:0]  dcache_we;
  logic        dcache_re, stall;
  logic        mem_req_valid, mem_req_ready, mem_req_rw;
  logic [31:0] mem_req_addr, mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_writes;
`endif

  dcache_responder dut (
    .clk            (clk),
    .reset          (reset),
    .dcache_addr    (dcache_addr),
    .dcache_we      (dcache_we),
    .dcache_re      (dcache_re),
    .dcache_din     (dcache_din),
    .dcache_dout    (dcache_dout),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_mask   (mem_req_mask),
    .mem_resp_valid (mem_resp_valid),
`ifdef DCACHE_STATS_EN
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses),
    .stat_writes    (stat_writes),
`endif
    .mem_resp_data  (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd_q [$];
  req_t        req_q [$];
  logic [31:0] mem_words [logic [31:0]];

  int          ready_lat     = 0;
  int          beats_left    = 0;
  int          beat_idx      = 0;
  int          beats_sent    = 0;
  int          refill_starts = 0;
  int          reqs_accepted = 0;
  logic [31:0] rf_addr       = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return 32'h0;
  endfunction

  // Backing memory: ready after ready_lat cycles of valid.
  initial begin : ready_gen
    int wcnt;
    wcnt = 0;
    mem_req_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!mem_req_valid) begin
        mem_req_ready = 1'b0;
        wcnt = 0;
      end else if (wcnt >= ready_lat) begin
        mem_req_ready = 1'b1;
      end else begin
        mem_req_ready = 1'b0;
        wcnt++;
      end
    end
  end

  // Backing memory: refill beats, one per cycle, ascending word order.
  initial begin : responder
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (beats_left > 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_rd(rf_addr + 32'(4 * beat_idx));
        beat_idx++;
        beats_left--;
        beats_sent++;
      end else begin
        mem_resp_valid = 1'b0;
      end
    end
  end

  // Monitor: sampled between edges; values seen here are those the next posedge captures.
  initial begin : monitor
    bit   pend, prev_wait;
    req_t cur, prev, e;
    logic [31:0] merged;
    pend = 1'b0;
    prev_wait = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        pend = 1'b0;
        prev_wait = 1'b0;
      end else begin
        if (pend) begin
          if (rd_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dout_unexpected: read accepted with no expectation, dout 0x%08h", dcache_dout);
          end else begin
            check("dout", dcache_dout, rd_q.pop_front());
          end
        end
        pend = !stall && dcache_re && (dcache_we == 4'b0000);

        cur = '{rw: mem_req_rw, addr: mem_req_addr, data: mem_req_data, mask: mem_req_mask};
        if (mem_req_valid && !mem_req_ready) begin
          check("stall_while_req_pending", {31'b0, stall}, 32'd1);
          if (prev_wait) check("req_stable", {31'b0, cur == prev}, 32'd1);
          prev_wait = 1'b1;
          prev = cur;
        end else begin
          prev_wait = 1'b0;
        end

        if (mem_req_valid && mem_req_ready) begin
          reqs_accepted++;
          if (req_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_unexpected: rw=%0b addr=0x%08h with nothing expected", mem_req_rw, mem_req_addr);
          end else begin
            e = req_q.pop_front();
            check("req_rw", {31'b0, cur.rw}, {31'b0, e.rw});
            check("req_addr", cur.addr, e.addr);
            if (e.rw) begin
              check("req_data", cur.data, e.data);
              check("req_mask", {28'b0, cur.mask}, {28'b0, e.mask});
            end
          end
          if (cur.rw) begin
            merged = mem_rd(cur.addr);
            for (int b = 0; b < 4; b++) if (cur.mask[b]) merged[8*b +: 8] = cur.data[8*b +: 8];
            mem_words[cur.addr] = merged;
          end else begin
            rf_addr = cur.addr;
            beat_idx = 0;
            beats_sent = 0;
            beats_left = LINE_WORDS;
            refill_starts++;
          end
        end
      end
    end
  end

  task automatic push_req(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    req_q.push_back('{rw: rw, addr: a, data: d, mask: m});
  endtask

  // Drive one request and hold it until accepted; exp_miss selects the latency check.
  task automatic issue(input logic [31:0] a, input logic [3:0] we, input logic [31:0] din,
                       input bit exp_miss, input logic [31:0] exp_dout);
    int n;
    @(negedge clk);
    dcache_addr = a;
    dcache_we   = we;
    dcache_din  = din;
    dcache_re   = (we == 4'b0000);
    if (we == 4'b0000) rd_q.push_back(exp_dout);
    n = 0;
    #1;
    while (stall && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_bound", (n < 200) ? 32'd1 : 32'd0, 32'd1);
    if (we == 4'b0000 && !exp_miss) check("hit_no_stall", 32'(n), 32'd0);
    if (we == 4'b0000 && exp_miss)  check("refill_beats_before_release", 32'(beats_sent), 32'(LINE_WORDS));
    @(posedge clk);
    @(negedge clk);
    dcache_re = 1'b0;
    dcache_we = 4'b0000;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n, starts0, reqs0;
    mem_words[32'h100]  = 32'hA0; mem_words[32'h104]  = 32'hA1;
    mem_words[32'h108]  = 32'hA2; mem_words[32'h10C]  = 32'hA3;
    mem_words[32'h500]  = 32'hB0; mem_words[32'h504]  = 32'hB1;
    mem_words[32'h508]  = 32'hB2; mem_words[32'h50C]  = 32'hB3;
    mem_words[32'h2000] = 32'hC0; mem_words[32'h2004] = 32'hC1;
    mem_words[32'h2008] = 32'hC2; mem_words[32'h200C] = 32'hC3;

    reset = 1'b0;
    dcache_addr = 32'h0; dcache_we = 4'b0; dcache_din = 32'h0; dcache_re = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout", dcache_dout, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'd0);
    check("reset_req_valid", {31'b0, mem_req_valid}, 32'd0);
    reset = 1'b1;

    // Cold miss then hit in the same line.
    push_req(1'b0, 32'h100, 32'h0, 4'h0);
    issue(32'h100, 4'b0000, 32'h0, 1'b1, 32'hA0);
    issue(32'h104, 4'b0000, 32'h0, 1'b0, 32'hA1);

    // Store hits merge bytes and write through.
    push_req(1'b1, 32'h108, 32'h0000BEEF, 4'b0011);
    issue(32'h108, 4'b0011, 32'h0000BEEF, 1'b0, 32'h0);
    issue(32'h108, 4'b0000, 32'h0, 1'b0, 32'h0000BEEF);
    push_req(1'b1, 32'h10C, 32'h12340000, 4'b1100);
    issue(32'h10C, 4'b1100, 32'h12340000, 1'b0, 32'h0);
    issue(32'h10C, 4'b0000, 32'h0, 1'b0, 32'h123400A3);

    // Store miss: write only, no allocate, so the next read refills from memory.
    push_req(1'b1, 32'h2000, 32'hCAFEF00D, 4'b1111);
    issue(32'h2000, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0);
    push_req(1'b0, 32'h2000, 32'h0, 4'h0);
    issue(32'h2000, 4'b0000, 32'h0, 1'b1, 32'hCAFEF00D);

    // Slow memory on a write.
    ready_lat = 5;
    reqs0 = reqs_accepted;
    push_req(1'b1, 32'h104, 32'h55000000, 4'b1000);
    issue(32'h104, 4'b1000, 32'h55000000, 1'b0, 32'h0);
    check("single_write_request", 32'(reqs_accepted - reqs0), 32'd1);
    ready_lat = 0;
    issue(32'h104, 4'b0000, 32'h0, 1'b0, 32'h550000A1);

    // Conflict: 0x500 maps onto the same set as 0x100.
    push_req(1'b0, 32'h500, 32'h0, 4'h0);
    issue(32'h500, 4'b0000, 32'h0, 1'b1, 32'hB0);
    push_req(1'b0, 32'h100, 32'h0, 4'h0);
    issue(32'h100, 4'b0000, 32'h0, 1'b1, 32'hA0);
    issue(32'h108, 4'b0000, 32'h0, 1'b0, 32'h0000BEEF);
    push_req(1'b0, 32'h500, 32'h0, 4'h0);
    issue(32'h500, 4'b0000, 32'h0, 1'b1, 32'hB0);

    // Reset after two refill beats of 0x100.
    push_req(1'b0, 32'h100, 32'h0, 4'h0);
    starts0 = refill_starts;
    @(negedge clk);
    dcache_addr = 32'h100; dcache_we = 4'b0000; dcache_re = 1'b1;
    n = 0;
    while ((refill_starts == starts0 || beats_sent < 2) && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("two_beats_bound", (n < 200) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    dcache_re = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrefill_reset_dout", dcache_dout, 32'h0);
    check("midrefill_reset_stall", {31'b0, stall}, 32'd0);
    check("midrefill_reset_req_valid", {31'b0, mem_req_valid}, 32'd0);
    repeat (6) @(negedge clk);

    push_req(1'b0, 32'h100, 32'h0, 4'h0);
    issue(32'h100, 4'b0000, 32'h0, 1'b1, 32'hA0);
    push_req(1'b0, 32'h2000, 32'h0, 4'h0);
    issue(32'h2000, 4'b0000, 32'h0, 1'b1, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
`ifdef DCACHE_STATS_EN
    check("stat_hits", stat_hits, 32'd2);
    check("stat_misses", stat_misses, 32'd2);
    check("stat_writes", stat_writes, 32'd0);
`endif
    check("dout_queue_drained", 32'(rd_q.size()), 32'd0);
    check("req_queue_drained", 32'(req_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
